// File: rtl/msg_request_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// fix_pkg
// Definitions shared by the FIX session blocks:
//   - message kind codes (KIND_LOGON .. KIND_BUSINESS)
//   - scheduler state enum (IDLE, ISSUE, WAIT)
//   - kind_valid(): true for a kind code that the create-message engine builds
// ----------------------------------------------------------------------------
package fix_pkg;

   localparam logic [2:0] KIND_LOGON      = 3'd1;
   localparam logic [2:0] KIND_LOGOUT     = 3'd2;
   localparam logic [2:0] KIND_RESEND_REQ = 3'd3;
   localparam logic [2:0] KIND_TEST_REPLY = 3'd4;
   localparam logic [2:0] KIND_HEARTBEAT  = 3'd5;
   localparam logic [2:0] KIND_BUSINESS   = 3'd6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } sched_state_e;

   function automatic logic kind_valid(input logic [2:0] kind);
      return (kind >= KIND_LOGON) && (kind <= KIND_BUSINESS);
   endfunction

endpackage

// File: rtl/msg_request_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Requests are scanned starting at ptr_i,
// wrapping modulo N; the first active request wins.
// Ports:
//   req_i  in  N   request vector
//   ptr_i  in  IW  index that has the highest priority this cycle
//   gnt_o  out N   one-hot grant (all zero when no request)
//   idx_o  out IW  index of the granted request (0 when no request)
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int unsigned N  = 3,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   logic        found;
   int unsigned j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned i = 0; i < N; i++) begin
         j = (32'(ptr_i) + i) % N;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/msg_request_scheduler.sv
// ----------------------------------------------------------------------------
// msg_request_scheduler
// Serialises create-message orders from the session manager onto the single
// create-message engine. One pending bit per (session, kind); sessions are
// picked round-robin, kinds within a session by fixed priority (lowest code
// first). One order is in flight at a time, guarded by a watchdog.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid_i       order strobe
//   req_session_i     session index of the order
//   req_kind_i        message kind (1..6)
//   req_addr_i        counterparty address for the session
//   disconnect_i      per session: flush all pending orders
//   engine_busy_i     create-message engine busy
//   engine_done_i     pulse: message built and sent
//   start_o           pulse: begin message
//   create_message_o  kind being issued
//   msg_session_o     session being issued
//   connectTo_o       address of the issued session
//   pending_o         per session: any kind pending
//   sched_busy_o      scheduler not idle
//   dropped_o         pulse: invalid order discarded
//   timeout_o         pulse: engine watchdog expired
// ----------------------------------------------------------------------------
module msg_request_scheduler
   import fix_pkg::*;
#(
   parameter int unsigned NUM_SESSION = 3,
   parameter int unsigned SID_W       = 2,
   parameter int unsigned ADDR        = 10,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid_i,
   input  logic [SID_W-1:0]       req_session_i,
   input  logic [2:0]             req_kind_i,
   input  logic [ADDR-1:0]        req_addr_i,
   input  logic [NUM_SESSION-1:0] disconnect_i,
   input  logic                   engine_busy_i,
   input  logic                   engine_done_i,
   output logic                   start_o,
   output logic [2:0]             create_message_o,
   output logic [SID_W-1:0]       msg_session_o,
   output logic [ADDR-1:0]        connectTo_o,
   output logic [NUM_SESSION-1:0] pending_o,
   output logic                   sched_busy_o,
   output logic                   dropped_o,
   output logic                   timeout_o
);

   localparam int unsigned      WD_W     = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [SID_W-1:0] SID_LAST = SID_W'(NUM_SESSION - 1);

   // pend_q[s][k-1] is the pending bit of kind k for session s
   logic [5:0]       pend_q [NUM_SESSION];
   logic [5:0]       pend_d [NUM_SESSION];
   logic [ADDR-1:0]  addr_q [NUM_SESSION];
   logic [ADDR-1:0]  addr_d [NUM_SESSION];

   sched_state_e     state_q, state_d;
   logic [SID_W-1:0] rr_q, rr_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic [2:0]       kind_q, kind_d;
   logic [SID_W-1:0] sess_q, sess_d;
   logic [ADDR-1:0]  conn_q, conn_d;
   logic             dropped_q, dropped_d;

   logic [NUM_SESSION-1:0] req_vec;
   logic [NUM_SESSION-1:0] win_gnt;
   logic [SID_W-1:0]       win_idx;
   logic                   win_valid;
   logic [5:0]             win_bits;
   logic [2:0]             win_kind;
   logic                   accept;
   logic                   timeout_c;

   always_comb begin
      for (int unsigned s = 0; s < NUM_SESSION; s++) begin
         req_vec[s] = |pend_q[s];
      end
   end

   rr_arbiter #(
      .N  (NUM_SESSION),
      .IW (SID_W)
   ) u_rr_arbiter (
      .req_i (req_vec),
      .ptr_i (rr_q),
      .gnt_o (win_gnt),
      .idx_o (win_idx)
   );

   // In-session priority: lowest kind code of the winning session
   always_comb begin
      win_bits = '0;
      win_kind = '0;
      for (int unsigned s = 0; s < NUM_SESSION; s++) begin
         if (win_gnt[s]) win_bits = pend_q[s];
      end
      for (int unsigned k = 0; k < 6; k++) begin
         if (win_bits[k] && (win_kind == 3'd0)) win_kind = 3'(k + 1);
      end
   end

   assign win_valid = |win_gnt;
   assign accept    = req_valid_i && kind_valid(req_kind_i) &&
                      (32'(req_session_i) < NUM_SESSION);

   always_comb begin
      pend_d    = pend_q;
      addr_d    = addr_q;
      state_d   = state_q;
      rr_d      = rr_q;
      wd_d      = wd_q;
      kind_d    = kind_q;
      sess_d    = sess_q;
      conn_d    = conn_q;
      dropped_d = req_valid_i && !accept;
      timeout_c = 1'b0;

      for (int unsigned s = 0; s < NUM_SESSION; s++) begin
         if (disconnect_i[s]) pend_d[s] = '0;
      end

      unique case (state_q)
         IDLE: begin
            if (win_valid && !engine_busy_i) begin
               sess_d  = win_idx;
               kind_d  = win_kind;
               rr_d    = (win_idx == SID_LAST) ? '0 : win_idx + 1'b1;
               state_d = ISSUE;
               for (int unsigned s = 0; s < NUM_SESSION; s++) begin
                  if (win_gnt[s]) begin
                     conn_d                       = addr_q[s];
                     pend_d[s][win_kind - 3'd1] = 1'b0;
                  end
               end
            end
         end
         ISSUE: begin
            wd_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (engine_done_i) begin
               state_d = IDLE;
            end else if (wd_q == WD_LAST) begin
               timeout_c = 1'b1;
               state_d   = IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Applied last so a new order wins over a flush or grant-clear
      for (int unsigned s = 0; s < NUM_SESSION; s++) begin
         if (accept && (SID_W'(s) == req_session_i)) begin
            pend_d[s][req_kind_i - 3'd1] = 1'b1;
            addr_d[s]                    = req_addr_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q    <= '{default: '0};
         addr_q    <= '{default: '0};
         state_q   <= IDLE;
         rr_q      <= '0;
         wd_q      <= '0;
         kind_q    <= '0;
         sess_q    <= '0;
         conn_q    <= '0;
         dropped_q <= 1'b0;
      end else begin
         pend_q    <= pend_d;
         addr_q    <= addr_d;
         state_q   <= state_d;
         rr_q      <= rr_d;
         wd_q      <= wd_d;
         kind_q    <= kind_d;
         sess_q    <= sess_d;
         conn_q    <= conn_d;
         dropped_q <= dropped_d;
      end
   end

   assign pending_o        = req_vec;
   assign start_o          = (state_q == ISSUE);
   assign sched_busy_o     = (state_q != IDLE);
   assign create_message_o = kind_q;
   assign msg_session_o    = sess_q;
   assign connectTo_o      = conn_q;
   assign dropped_o        = dropped_q;
   // A reset abandons the order in flight without reporting a timeout
   assign timeout_o        = timeout_c && !rst;

endmodule

// File: tb/tb_msg_request_scheduler.sv
module tb_msg_request_scheduler;

   localparam int NS = 3;
   localparam int SW = 2;
   localparam int AW = 10;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid_i = 1'b0;
   logic [SW-1:0] req_session_i = '0;
   logic [2:0]    req_kind_i = '0;
   logic [AW-1:0] req_addr_i = '0;
   logic [NS-1:0] disconnect_i = '0;
   logic          engine_busy_i = 1'b0;
   logic          engine_done_i = 1'b0;
   logic          start_o;
   logic [2:0]    create_message_o;
   logic [SW-1:0] msg_session_o;
   logic [AW-1:0] connectTo_o;
   logic [NS-1:0] pending_o;
   logic          sched_busy_o;
   logic          dropped_o;
   logic          timeout_o;

   always #5 clk = ~clk;

   msg_request_scheduler #(
      .NUM_SESSION (NS),
      .SID_W       (SW),
      .ADDR        (AW),
      .TIMEOUT     (TO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid_i      (req_valid_i),
      .req_session_i    (req_session_i),
      .req_kind_i       (req_kind_i),
      .req_addr_i       (req_addr_i),
      .disconnect_i     (disconnect_i),
      .engine_busy_i    (engine_busy_i),
      .engine_done_i    (engine_done_i),
      .start_o          (start_o),
      .create_message_o (create_message_o),
      .msg_session_o    (msg_session_o),
      .connectTo_o      (connectTo_o),
      .pending_o        (pending_o),
      .sched_busy_o     (sched_busy_o),
      .dropped_o        (dropped_o),
      .timeout_o        (timeout_o)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 = no order in flight, 1 = start cycle, 2 = waiting for engine
   bit [6:1]      m_pend [NS];
   logic [AW-1:0] m_addr [NS];
   int            m_rr = 0;
   int            m_phase = 0;
   int            m_wait_n = 0;
   logic [2:0]    m_kind = '0;
   logic [SW-1:0] m_sess = '0;
   logic [AW-1:0] m_conn = '0;
   bit            m_drop = 1'b0;

   always @(posedge clk) begin
      bit grant;
      int gs, gk;
      bit ok;
      grant = 1'b0; gs = 0; gk = 0;
      if (rst) begin
         for (int s = 0; s < NS; s++) begin m_pend[s] = '0; m_addr[s] = '0; end
         m_rr = 0; m_phase = 0; m_wait_n = 0;
         m_kind = '0; m_sess = '0; m_conn = '0; m_drop = 1'b0;
      end else begin
         if (m_phase == 0 && !engine_busy_i) begin
            for (int i = 0; i < NS; i++) begin
               for (int k = 1; k <= 6; k++) begin
                  if (!grant && m_pend[(m_rr + i) % NS][k]) begin
                     grant = 1'b1; gs = (m_rr + i) % NS; gk = k;
                  end
               end
            end
         end
         case (m_phase)
            0: if (grant) begin
                  m_phase = 1;
                  m_kind  = 3'(gk);
                  m_sess  = SW'(gs);
                  m_conn  = m_addr[gs];
                  m_rr    = (gs + 1) % NS;
               end
            1: begin m_phase = 2; m_wait_n = 0; end
            default: begin
               if (engine_done_i || m_wait_n == TO - 1) m_phase = 0;
               else m_wait_n++;
            end
         endcase
         for (int s = 0; s < NS; s++) if (disconnect_i[s]) m_pend[s] = '0;
         if (grant) m_pend[gs][gk] = 1'b0;
         ok = req_valid_i && req_kind_i >= 1 && req_kind_i <= 6 && int'(req_session_i) < NS;
         if (ok) begin
            m_pend[req_session_i][req_kind_i] = 1'b1;
            m_addr[req_session_i] = req_addr_i;
         end
         m_drop = req_valid_i && !ok;
      end
   end

   always @(negedge clk) begin
      logic [NS-1:0] ep;
      bit            eto;
      if (chk_en) begin
         for (int s = 0; s < NS; s++) ep[s] = |m_pend[s];
         eto = (m_phase == 2) && !engine_done_i && (m_wait_n == TO - 1) && !rst;
         chk("m_start",   start_o,          m_phase == 1);
         chk("m_busy",    sched_busy_o,     m_phase != 0);
         chk("m_kind",    create_message_o, m_kind);
         chk("m_session", msg_session_o,    m_sess);
         chk("m_connect", connectTo_o,      m_conn);
         chk("m_pending", pending_o,        ep);
         chk("m_dropped", dropped_o,        m_drop);
         chk("m_timeout", timeout_o,        eto);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic post(input int s, input int k, input int a);
      req_valid_i = 1'b1; req_session_i = SW'(s); req_kind_i = 3'(k); req_addr_i = AW'(a);
      tick();
      req_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid_i = 1'b0; disconnect_i = '0;
      engine_busy_i = 1'b0; engine_done_i = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic wait_issue(input string nm, input int s, input int k, input int a);
      for (int i = 0; i < 40 && !start_o; i++) tick();
      chk({nm, "_start"},   start_o, 1);
      chk({nm, "_kind"},    create_message_o, k);
      chk({nm, "_session"}, msg_session_o, s);
      chk({nm, "_connect"}, connectTo_o, a);
   endtask

   task automatic finish_issue(input string nm, input int n);
      repeat (n) tick();
      engine_done_i = 1'b1;
      tick();
      engine_done_i = 1'b0;
      chk({nm, "_idle"}, sched_busy_o, 0);
   endtask

   task automatic count_starts(input string nm, input int n);
      int cnt;
      cnt = 0;
      repeat (n) begin tick(); cnt += int'(start_o); end
      chk(nm, cnt, 0);
   endtask

   initial begin
      int starts;
      int done_pct;
      tick(); tick();
      chk_en = 1'b1;
      rst = 1'b0;

      // single order and latency
      post(1, 5, 'h2A);
      chk("t1_pending", pending_o, 3'b010);
      tick();
      chk("t1_latency", start_o, 1);
      wait_issue("t1", 1, 5, 'h2A);
      finish_issue("t1", 4);

      // round robin from pointer 0
      do_reset();
      engine_busy_i = 1'b1;
      post(0, 6, 1); post(1, 6, 2); post(2, 6, 3);
      engine_busy_i = 1'b0;
      wait_issue("t2a", 0, 6, 1); finish_issue("t2a", 1);
      wait_issue("t2b", 1, 6, 2); finish_issue("t2b", 1);
      wait_issue("t2c", 2, 6, 3);
      post(0, 6, 4);
      finish_issue("t2c", 1);
      wait_issue("t2d", 0, 6, 4); finish_issue("t2d", 1);

      // kind priority within one session
      engine_busy_i = 1'b1;
      post(0, 6, 5); post(0, 5, 6); post(0, 1, 7);
      engine_busy_i = 1'b0;
      wait_issue("t3a", 0, 1, 7); finish_issue("t3a", 1);
      wait_issue("t3b", 0, 5, 7); finish_issue("t3b", 1);
      wait_issue("t3c", 0, 6, 7); finish_issue("t3c", 1);

      // engine busy hold
      engine_busy_i = 1'b1;
      post(1, 2, 8); post(2, 3, 9);
      count_starts("t4_no_start", 20);
      engine_busy_i = 1'b0;
      tick();
      chk("t4_first_grant", start_o, 1);
      wait_issue("t4a", 1, 2, 8); finish_issue("t4a", 1);
      wait_issue("t4b", 2, 3, 9); finish_issue("t4b", 1);

      // coalesce
      engine_busy_i = 1'b1;
      post(2, 5, 'h10); post(2, 5, 'h11);
      engine_busy_i = 1'b0;
      wait_issue("t5", 2, 5, 'h11); finish_issue("t5", 2);
      count_starts("t5_single", 8);
      chk("t5_pending", pending_o, 0);

      // flush
      engine_busy_i = 1'b1;
      post(2, 5, 'h12);
      chk("t6_pending_set", pending_o, 3'b100);
      disconnect_i = 3'b100; tick(); disconnect_i = '0;
      chk("t6_pending_clr", pending_o, 0);
      engine_busy_i = 1'b0;
      count_starts("t6_no_issue", 8);

      // same-cycle flush and new order
      engine_busy_i = 1'b1;
      post(2, 5, 'h13);
      disconnect_i = 3'b100; post(2, 4, 'h14); disconnect_i = '0;
      chk("t7_pending", pending_o, 3'b100);
      engine_busy_i = 1'b0;
      wait_issue("t7", 2, 4, 'h14); finish_issue("t7", 1);
      count_starts("t7_flushed", 8);

      // invalid orders
      post(0, 7, 'h3FF);
      chk("t8_drop_kind", dropped_o, 1);
      post(3, 5, 'h3FF);
      chk("t8_drop_sess", dropped_o, 1);
      tick();
      chk("t8_drop_end", dropped_o, 0);
      chk("t8_pending", pending_o, 0);

      // watchdog
      post(0, 6, 'h20);
      wait_issue("t9", 0, 6, 'h20);
      starts = 0;
      repeat (15) begin tick(); starts += int'(timeout_o); end
      chk("t9_early", starts, 0);
      tick();
      chk("t9_timeout", timeout_o, 1);
      tick();
      chk("t9_idle", sched_busy_o, 0);
      chk("t9_pulse", timeout_o, 0);

      // reset mid-WAIT
      post(1, 3, 'h155);
      wait_issue("t10", 1, 3, 'h155);
      tick(); tick();
      rst = 1'b1; tick();
      chk("t10_start", start_o, 0);
      chk("t10_busy", sched_busy_o, 0);
      chk("t10_kind", create_message_o, 0);
      chk("t10_session", msg_session_o, 0);
      chk("t10_connect", connectTo_o, 0);
      chk("t10_pending", pending_o, 0);
      chk("t10_timeout", timeout_o, 0);
      rst = 1'b0;
      tick();

      // randomized traffic against the model
      done_pct = 35;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) done_pct = ($urandom_range(0, 3) == 0) ? 0 : 35;
         req_valid_i   = ($urandom_range(0, 99) < 40);
         req_session_i = SW'($urandom_range(0, 3));
         req_kind_i    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                                     : 3'($urandom_range(1, 6));
         req_addr_i    = AW'($urandom);
         disconnect_i  = ($urandom_range(0, 99) < 5) ? NS'($urandom_range(1, 7)) : '0;
         engine_busy_i = ($urandom_range(0, 99) < 20);
         engine_done_i = ($urandom_range(0, 99) < done_pct);
         rst           = (c == 1500);
         tick();
      end
      rst = 1'b0; req_valid_i = 1'b0; disconnect_i = '0;
      engine_busy_i = 1'b0; engine_done_i = 1'b0;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
